// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: single-outstanding imem fetch feeding a
// DEPTH-entry parcel FIFO whose head is presented to the core.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   if_nxt_pc             next PC offered by the core
//   if_stall_nxt_pc       1 = if_nxt_pc not taken this cycle
//   if_stall, if_flush    core hold of head parcel / discard everything
//   if_parcel*            head parcel, its PC, valid mask and fault flags
//   imem_req, imem_adr    fetch request to instruction memory
//   imem_ack, imem_err    fetch completion (data / error)
//   imem_q                fetched data
//   imem_misaligned       fault flag, sampled with ack/err
//   imem_page_fault       fault flag, sampled with ack/err
module if_prefetch_queue #(
  parameter int          XLEN        = 32,
  parameter logic [XLEN-1:0] PC_INIT = 'h200,
  parameter int          PARCEL_SIZE = 32,
  parameter int          DEPTH       = 4
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [XLEN-1:0]         if_nxt_pc,
  output logic                    if_stall_nxt_pc,
  input  logic                    if_stall,
  input  logic                    if_flush,
  output logic [PARCEL_SIZE-1:0]  if_parcel,
  output logic [XLEN-1:0]         if_parcel_pc,
  output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
  output logic                    if_parcel_misaligned,
  output logic                    if_parcel_page_fault,
  output logic                    if_parcel_error,

  output logic                    imem_req,
  output logic [XLEN-1:0]         imem_adr,
  input  logic                    imem_ack,
  input  logic                    imem_err,
  input  logic [PARCEL_SIZE-1:0]  imem_q,
  input  logic                    imem_misaligned,
  input  logic                    imem_page_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int PV = PARCEL_SIZE / 16;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [PARCEL_SIZE-1:0] mem_q   [DEPTH];
  logic [XLEN-1:0]        mem_pc  [DEPTH];
  logic                   mem_mis [DEPTH];
  logic                   mem_pf  [DEPTH];
  logic                   mem_err [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          req_busy;
  logic          drop_pending;

  logic          rsp;
  logic          accept;
  logic          push;
  logic          pop;
  logic          not_empty;
  logic [AW:0]   occ;

  // A response only counts against an outstanding request.
  assign rsp       = (imem_ack | imem_err) & req_busy;
  assign not_empty = (cnt != '0);

  // Buffered entries plus the in-flight one must leave room for one more.
  assign occ = cnt + {{AW{1'b0}}, req_busy};

  assign accept = !if_flush
                & !drop_pending
                & (!req_busy | rsp)
                & (occ < DEPTH_W);

  assign if_stall_nxt_pc = !accept;

  assign push = rsp & !drop_pending & !if_flush;
  assign pop  = not_empty & !if_stall & !if_flush;

  // Request side: a request stays on the bus until its ack/err.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_req     <= 1'b0;
      imem_adr     <= PC_INIT;
      req_busy     <= 1'b0;
      drop_pending <= 1'b0;
    end else begin
      if (accept) begin
        imem_req <= 1'b1;
        imem_adr <= if_nxt_pc;
        req_busy <= 1'b1;
      end else if (rsp) begin
        imem_req <= 1'b0;
        req_busy <= 1'b0;
      end

      // A flush cannot withdraw a live request, so its
      // eventual response is marked for discard instead.
      if (rsp)
        drop_pending <= 1'b0;
      else if (if_flush & req_busy)
        drop_pending <= 1'b1;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (if_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        push & !pop: cnt <= cnt + (AW+1)'(1);
        pop & !push: cnt <= cnt - (AW+1)'(1);
        default:     cnt <= cnt;
      endcase
    end
  end

  // FIFO storage; an errored fetch stores a zero parcel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]   <= '0;
        mem_pc[i]  <= '0;
        mem_mis[i] <= 1'b0;
        mem_pf[i]  <= 1'b0;
        mem_err[i] <= 1'b0;
      end
    end else if (push) begin
      mem_q[wr_ptr]   <= imem_err ? '0 : imem_q;
      mem_pc[wr_ptr]  <= imem_adr;
      mem_mis[wr_ptr] <= imem_misaligned;
      mem_pf[wr_ptr]  <= imem_page_fault;
      mem_err[wr_ptr] <= imem_err;
    end
  end

  // Head presentation, zeroed while empty.
  always_comb begin
    if_parcel            = '0;
    if_parcel_pc         = '0;
    if_parcel_valid      = '0;
    if_parcel_misaligned = 1'b0;
    if_parcel_page_fault = 1'b0;
    if_parcel_error      = 1'b0;
    if (not_empty) begin
      if_parcel            = mem_q[rd_ptr];
      if_parcel_pc         = mem_pc[rd_ptr];
      if_parcel_valid      = {PV{1'b1}};
      if_parcel_misaligned = mem_mis[rd_ptr];
      if_parcel_page_fault = mem_pf[rd_ptr];
      if_parcel_error      = mem_err[rd_ptr];
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Random-stimulus bench for if_prefetch_queue against a queue-based
// reference model of the fetch/buffer/flush rules.
module tb_if_prefetch_queue;

  localparam int XLEN  = 32;
  localparam int PS    = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] PC_INIT = 32'h200;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] if_nxt_pc;
  logic            if_stall_nxt_pc;
  logic            if_stall;
  logic            if_flush;
  logic [PS-1:0]   if_parcel;
  logic [XLEN-1:0] if_parcel_pc;
  logic [PS/16-1:0] if_parcel_valid;
  logic            if_parcel_misaligned;
  logic            if_parcel_page_fault;
  logic            if_parcel_error;
  logic            imem_req;
  logic [XLEN-1:0] imem_adr;
  logic            imem_ack;
  logic            imem_err;
  logic [PS-1:0]   imem_q;
  logic            imem_misaligned;
  logic            imem_page_fault;

  always #5 clk = ~clk;

  if_prefetch_queue #(
    .XLEN(XLEN), .PC_INIT(PC_INIT),
    .PARCEL_SIZE(PS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .if_nxt_pc(if_nxt_pc),
    .if_stall_nxt_pc(if_stall_nxt_pc),
    .if_stall(if_stall), .if_flush(if_flush),
    .if_parcel(if_parcel),
    .if_parcel_pc(if_parcel_pc),
    .if_parcel_valid(if_parcel_valid),
    .if_parcel_misaligned(if_parcel_misaligned),
    .if_parcel_page_fault(if_parcel_page_fault),
    .if_parcel_error(if_parcel_error),
    .imem_req(imem_req), .imem_adr(imem_adr),
    .imem_ack(imem_ack), .imem_err(imem_err),
    .imem_q(imem_q),
    .imem_misaligned(imem_misaligned),
    .imem_page_fault(imem_page_fault)
  );

  typedef struct {
    logic [PS-1:0]   d;
    logic [XLEN-1:0] pc;
    logic            mis;
    logic            pf;
    logic            er;
  } ent_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  ent_t            q[$];
  logic            m_busy;
  logic            m_drop;
  logic [XLEN-1:0] m_adr;
  int              dly;

  task automatic model_reset();
    q.delete();
    m_busy = 1'b0;
    m_drop = 1'b0;
    m_adr  = PC_INIT;
    dly    = 0;
  endtask

  initial begin
    int stall_pct;
    int flush_pct;
    int err_pct;
    logic rsp;
    logic acc;
    ent_t e;

    rst = 1'b1;
    if_nxt_pc = '0;
    if_stall = 1'b0;
    if_flush = 1'b0;
    imem_ack = 1'b0;
    imem_err = 1'b0;
    imem_q = '0;
    imem_misaligned = 1'b0;
    imem_page_fault = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    for (int ph = 0; ph < 4; ph++) begin
      unique case (ph)
        0: begin stall_pct = 10; flush_pct = 0;  err_pct = 0;  end
        1: begin stall_pct = 70; flush_pct = 0;  err_pct = 10; end
        2: begin stall_pct = 30; flush_pct = 8;  err_pct = 15; end
        default:
           begin stall_pct = 40; flush_pct = 20; err_pct = 25; end
      endcase

      for (int cyc = 0; cyc < 600; cyc++) begin
        @(negedge clk);
        rst = (cyc == 0);
        if_nxt_pc = {$urandom_range(0, 255), 2'b00} + 32'h200;
        if_stall  = ($urandom_range(0, 99) < stall_pct);
        if_flush  = !rst && ($urandom_range(0, 99) < flush_pct);
        imem_ack  = 1'b0;
        imem_err  = 1'b0;
        imem_q    = $urandom;
        imem_misaligned = ($urandom_range(0, 7) == 0);
        imem_page_fault = ($urandom_range(0, 7) == 0);
        if (!rst && m_busy) begin
          if (dly == 0) begin
            if ($urandom_range(0, 99) < err_pct)
              imem_err = 1'b1;
            else
              imem_ack = 1'b1;
          end else begin
            dly--;
          end
        end else if (!rst && $urandom_range(0, 15) == 0) begin
          // stray response with nothing outstanding
          imem_ack = 1'b1;
        end
        #1;

        rsp = m_busy & (imem_ack | imem_err);
        acc = !if_flush & !m_drop & (!m_busy | rsp)
            & ((q.size() + int'(m_busy)) < DEPTH);

        chk("stall_nxt_pc", 64'(if_stall_nxt_pc), 64'(!acc));
        chk("imem_req", 64'(imem_req), 64'(m_busy));
        chk("imem_adr", 64'(imem_adr), 64'(m_adr));
        if (q.size() > 0) begin
          chk("parcel", 64'(if_parcel), 64'(q[0].d));
          chk("parcel_pc", 64'(if_parcel_pc), 64'(q[0].pc));
          chk("parcel_valid", 64'(if_parcel_valid), 64'(2'b11));
          chk("parcel_mis", 64'(if_parcel_misaligned),
              64'(q[0].mis));
          chk("parcel_pf", 64'(if_parcel_page_fault),
              64'(q[0].pf));
          chk("parcel_err", 64'(if_parcel_error), 64'(q[0].er));
        end else begin
          chk("empty_parcel", 64'(if_parcel), 64'(0));
          chk("empty_pc", 64'(if_parcel_pc), 64'(0));
          chk("empty_valid", 64'(if_parcel_valid), 64'(0));
          chk("empty_flags",
              64'({if_parcel_misaligned, if_parcel_page_fault,
                   if_parcel_error}), 64'(0));
        end

        if (rst) begin
          model_reset();
        end else begin
          if (if_flush) begin
            q.delete();
          end else begin
            if (q.size() > 0 && !if_stall)
              void'(q.pop_front());
            if (rsp && !m_drop) begin
              e.d   = imem_err ? '0 : imem_q;
              e.pc  = m_adr;
              e.mis = imem_misaligned;
              e.pf  = imem_page_fault;
              e.er  = imem_err;
              q.push_back(e);
            end
          end
          if (rsp)
            m_drop = 1'b0;
          else if (if_flush && m_busy)
            m_drop = 1'b1;
          if (acc) begin
            m_busy = 1'b1;
            m_adr  = if_nxt_pc;
            dly    = $urandom_range(0, 3);
          end else if (rsp) begin
            m_busy = 1'b0;
          end
        end
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the core's fetch interface (if_nxt_pc / if_parcel*).
- Accepts the next-PC from the core and issues single-outstanding requests to the instruction memory bus interface.
- Buffers returned parcels, tagged with their PC and fault flags, in a DEPTH-entry FIFO.
- Presents the FIFO head to the core and honours the core's stall and flush.

Parameters:
XLEN, 32, address/PC width
PC_INIT, 'h200, reset value of imem_adr
PARCEL_SIZE, 32, fetched parcel width (multiple of 16)
DEPTH, 4, FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
if_nxt_pc  in  XLEN  next PC requested by core
if_stall_nxt_pc  out  1  1 = if_nxt_pc not accepted this cycle
if_stall  in  1  core not consuming head parcel
if_flush  in  1  discard all buffered/in-flight parcels
if_parcel  out  PARCEL_SIZE  head parcel
if_parcel_pc  out  XLEN  PC of head parcel
if_parcel_valid  out  PARCEL_SIZE/16  per-16-bit valid of head
if_parcel_misaligned  out  1  head fetch misaligned
if_parcel_page_fault  out  1  head fetch page fault
if_parcel_error  out  1  head fetch bus error
imem_req  out  1  fetch request
imem_adr  out  XLEN  fetch address
imem_ack  in  1  fetch completed, imem_q valid
imem_err  in  1  fetch terminated with error
imem_q  in  PARCEL_SIZE  fetched data
imem_misaligned  in  1  sampled with ack/err
imem_page_fault  in  1  sampled with ack/err

Behaviour:
- Reset (rst=1 at edge):
  - imem_req=0, imem_adr=PC_INIT.
  - FIFO empty, cnt=0, req_busy=0, drop_pending=0.
  - All FIFO storage cleared.
- rsp = imem_ack | imem_err. It is only meaningful while req_busy=1; rsp with req_busy=0 is ignored.
- Accept condition: accept = !if_flush & !drop_pending & (!req_busy | rsp) & (cnt + req_busy < DEPTH). cnt is the registered FIFO occupancy.
- if_stall_nxt_pc = !accept. It is combinational on imem_ack/imem_err/if_flush.
- On accept:
  - imem_adr <= if_nxt_pc, imem_req <= 1, req_busy <= 1 (request visible the cycle after accept).
  - Back-to-back operation: rsp and accept in the same cycle keep imem_req high with the new address next cycle.
- rsp without accept: imem_req <= 0, req_busy <= 0.
- Bus rule: imem_req and imem_adr are held stable while req_busy & !rsp. A request is never withdrawn before its ack/err, including across a flush.
- Push: on rsp & req_busy & !drop_pending & !if_flush, write the entry {imem_q, imem_adr, misaligned, page_fault, err}.
  - On imem_err the stored parcel is 0 and the error bit is 1.
  - The entry is visible at the outputs the cycle after rsp.
- Pop: when cnt>0 & !if_stall & !if_flush. Push and pop may occur in the same cycle; cnt is then unchanged.
- Overflow is impossible by the accept rule: cnt + outstanding <= DEPTH always.
- Head outputs:
  - cnt>0: head entry fields, with if_parcel_valid = all ones.
  - cnt=0: all if_parcel* outputs are 0.
- Flush (if_flush=1):
  - FIFO emptied next cycle (cnt=0, pointers reset); no pop, no push, no accept in this cycle.
  - If req_busy & !rsp: drop_pending <= 1.
  - Flush coincident with rsp: that response is discarded and req_busy <= 0.
- Drop pending:
  - While drop_pending=1, the response that arrives is discarded, and drop_pending and req_busy clear on it.
  - Acceptance resumes the cycle after that response.
- Reset mid-transaction: the bus response to an abandoned request must not be issued by the memory side after reset. The system ties rst to both sides, so this block assumes no stale response.
- Pointers are log2(DEPTH) bits and wrap naturally; cnt is log2(DEPTH)+1 bits.

Test Plan:
- Reset, then if_nxt_pc=0x200/0x204/0x208 with imem_ack the cycle after each imem_req, if_stall=0 -> imem_adr sequence 0x200,0x204,0x208 back-to-back; if_parcel_pc 0x200,0x204,0x208 on consecutive cycles; if_parcel_valid=2'b11.
- if_stall=1 held, immediate acks -> 4 parcels buffered; if_stall_nxt_pc=1 once cnt+req_busy=4; no 5th imem_req. Release stall -> parcels drain in order, fetching resumes.
- Ack delayed 3 cycles -> imem_req/imem_adr stable for 3 cycles; if_stall_nxt_pc=1 throughout.
- if_flush while a request to 0x300 is pending, ack 2 cycles later with imem_q=0xDEADBEEF -> FIFO empty; 0xDEADBEEF never appears on if_parcel; if_stall_nxt_pc=0 the cycle after the ack; new PC 0x400 is fetched next.
- imem_err with imem_page_fault=1 at PC 0x500 -> head shows if_parcel=0, if_parcel_error=1, if_parcel_page_fault=1, if_parcel_pc=0x500.
- Flush and imem_ack in the same cycle, FIFO holding 2 entries -> cnt=0 next cycle, acked data dropped, drop_pending stays 0, accept re-enabled the following cycle.
